// File: rtl/mem_controller_pkg.sv
// rtl/mem_controller_pkg.sv - shared types and defaults for the miss-service memory stage
package mem_controller_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_FILL = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Wait counter reload: an access spends LAT edges in its state, the last at count zero.
   function automatic logic [CNT_W-1:0] lat_reload(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_controller_mem_array.sv
// rtl/mem_controller_mem_array.sv - word-per-line backing array, sync write, read muxed to controller
module mem_controller_mem_array
   import mem_controller_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              i_clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] w_words [DEPTH];

   // Each word powers up holding its own address so fills are recognisable before any write.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [DATA_W-1:0] r_word = DATA_W'(i);

      always_ff @(posedge i_clock) begin
         if (i_we && (i_waddr == ADDR_W'(i))) begin
            r_word <= i_wdata;
         end
      end

      assign w_words[i] = r_word;
   end

   assign o_rdata = w_words[i_raddr];

endmodule

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - one-miss-at-a-time write-back + fill controller with modelled latency
// Optional MEMCTRL_FWD_EN: skip the fill when the evicted line is the one being refilled.
module mem_controller
   import mem_controller_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LAT    = 3
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_wb_en,
   input  logic [ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic [ADDR_W-1:0] i_fill_addr,
   output logic              o_resp_valid,
   output logic [DATA_W-1:0] o_resp_data,
   output logic              o_busy
);

   localparam logic [CNT_W-1:0] RELOAD = lat_reload(LAT);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_wb_addr;
   logic [ADDR_W-1:0] r_fill_addr;
   logic [DATA_W-1:0] r_wb_data;
   logic              w_cnt_done;
   logic              w_we;
   logic [DATA_W-1:0] w_rdata;

   assign w_cnt_done = (r_cnt == '0);
   // A reset landing on the completion edge still suppresses the write.
   assign w_we       = (r_state == ST_WB) && w_cnt_done && !i_reset;

   mem_controller_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .i_clock (i_clock),
      .i_we    (w_we),
      .i_waddr (r_wb_addr),
      .i_wdata (r_wb_data),
      .i_raddr (r_fill_addr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_data  <= '0;
         o_busy       <= 1'b0;
      end else begin
         o_resp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  r_wb_addr   <= i_wb_addr;
                  r_wb_data   <= i_wb_data;
                  r_fill_addr <= i_fill_addr;
                  r_cnt       <= RELOAD;
                  r_state     <= i_wb_en ? ST_WB : ST_FILL;
                  o_req_ready <= 1'b0;
                  o_busy      <= 1'b1;
               end
            end
            ST_WB: begin
               if (!w_cnt_done) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_cnt <= RELOAD;
`ifdef MEMCTRL_FWD_EN
                  if (r_wb_addr == r_fill_addr) begin
                     o_resp_data  <= r_wb_data;
                     o_resp_valid <= 1'b1;
                     r_state      <= ST_RESP;
                  end else begin
                     r_state <= ST_FILL;
                  end
`else
                  r_state <= ST_FILL;
`endif
               end
            end
            ST_FILL: begin
               if (!w_cnt_done) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  o_resp_data  <= w_rdata;
                  o_resp_valid <= 1'b1;
                  r_state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_state     <= ST_IDLE;
               o_req_ready <= 1'b1;
               o_busy      <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - vector table, corner sequences and random traffic against a memory model
module tb_mem_controller;

`ifdef MEMCTRL_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int LAT_A = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a_req_valid, a_req_ready, a_wb_en, a_resp_valid, a_busy;
   logic [4:0] a_wb_addr, a_fill_addr;
   logic [7:0] a_wb_data, a_resp_data;
   logic       b_req_valid, b_req_ready, b_wb_en, b_resp_valid, b_busy;
   logic [4:0] b_wb_addr, b_fill_addr;
   logic [7:0] b_wb_data, b_resp_data;

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] ref_mem [32];

   typedef struct {
      logic       wb_en;
      logic [4:0] wb_addr;
      logic [7:0] wb_data;
      logic [4:0] fill_addr;
      logic [7:0] exp_data;
      int         exp_lat;
   } vec_t;
   vec_t vecs [6];

   mem_controller #(.ADDR_W(5), .DATA_W(8), .LAT(LAT_A)) u_dut_a (
      .i_clock(clk), .i_reset(rst), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
      .i_wb_en(a_wb_en), .i_wb_addr(a_wb_addr), .i_wb_data(a_wb_data), .i_fill_addr(a_fill_addr),
      .o_resp_valid(a_resp_valid), .o_resp_data(a_resp_data), .o_busy(a_busy)
   );

   mem_controller #(.ADDR_W(5), .DATA_W(8), .LAT(1)) u_dut_b (
      .i_clock(clk), .i_reset(rst), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
      .i_wb_en(b_wb_en), .i_wb_addr(b_wb_addr), .i_wb_data(b_wb_data), .i_fill_addr(b_fill_addr),
      .o_resp_valid(b_resp_valid), .o_resp_data(b_resp_data), .o_busy(b_busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int model_lat(input logic wb, input logic [4:0] wa, input logic [4:0] fa);
      if (!wb) return LAT_A;
      return (FWD && wa == fa) ? LAT_A : 2 * LAT_A;
   endfunction

   task automatic run_req(input logic wb, input logic [4:0] wa, input logic [7:0] wd,
                          input logic [4:0] fa, input logic [7:0] exp_d, input int exp_lat,
                          input string nm);
      int n;
      bit seen, bad;
      @(negedge clk);
      check({nm, " ready"}, 32'(a_req_ready), 32'd1);
      a_req_valid = 1'b1; a_wb_en = wb; a_wb_addr = wa; a_wb_data = wd; a_fill_addr = fa;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      a_wb_en = 1'($urandom); a_wb_addr = 5'($urandom);
      a_wb_data = 8'($urandom); a_fill_addr = 5'($urandom);
      n = 0; seen = 1'b0; bad = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (a_busy !== 1'b1 || a_req_ready !== 1'b0) bad = 1'b1;
         if (a_resp_valid === 1'b1) seen = 1'b1;
      end
      check({nm, " resp seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({nm, " latency"}, 32'(n), 32'(exp_lat));
         check({nm, " data"}, 32'(a_resp_data), 32'(exp_d));
      end
      check({nm, " busy/ready while active"}, 32'(bad), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({nm, " back idle"}, 32'({a_resp_valid, a_req_ready, a_busy, a_resp_data}),
            32'({3'b010, exp_d}));
   endtask

   initial begin
      int pulses;
      bit seen;
      logic [4:0] v [9];
      logic       wb;
      logic [4:0] wa, fa;
      logic [7:0] wd;

      for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i);

      vecs[0] = '{1'b0, 5'd0,  8'h00, 5'd5,  8'h05, 3};
      vecs[1] = '{1'b1, 5'd2,  8'hA7, 5'd9,  8'h09, 6};
      vecs[2] = '{1'b0, 5'd0,  8'h00, 5'd2,  8'hA7, 3};
      vecs[3] = '{1'b1, 5'd4,  8'h3C, 5'd4,  8'h3C, FWD ? 3 : 6};
      vecs[4] = '{1'b1, 5'd10, 8'h55, 5'd2,  8'hA7, 6};
      vecs[5] = '{1'b0, 5'd0,  8'h00, 5'd10, 8'h55, 3};

      rst = 1'b1;
      a_req_valid = 1'b0; a_wb_en = 1'b0; a_wb_addr = '0; a_wb_data = '0; a_fill_addr = '0;
      b_req_valid = 1'b0; b_wb_en = 1'b0; b_wb_addr = '0; b_wb_data = '0; b_fill_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset a", 32'({a_req_ready, a_resp_valid, a_busy, a_resp_data}), 32'({3'b100, 8'h00}));
      check("reset b", 32'({b_req_ready, b_resp_valid, b_busy, b_resp_data}), 32'({3'b100, 8'h00}));
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_req(vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data, vecs[i].fill_addr,
                 vecs[i].exp_data, vecs[i].exp_lat, $sformatf("vec%0d", i));
         if (vecs[i].wb_en) ref_mem[vecs[i].wb_addr] = vecs[i].wb_data;
      end

      // req_valid held through a busy period with inputs wandering
      @(negedge clk);
      a_req_valid = 1'b1; a_wb_en = 1'b0; a_fill_addr = 5'd20;
      pulses = 0;
      for (int e = 0; e <= 9; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (a_resp_valid === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               check("hold first edge", 32'(e), 32'd3);
               check("hold first data", 32'(a_resp_data), 32'h14);
            end else if (pulses == 2) begin
               check("hold second edge", 32'(e), 32'd8);
               check("hold second data", 32'(a_resp_data), 32'h15);
            end
         end
         if (e < 3) begin
            a_wb_en = 1'($urandom); a_wb_addr = 5'($urandom);
            a_wb_data = 8'($urandom); a_fill_addr = 5'($urandom);
         end
         if (e == 3) begin a_wb_en = 1'b0; a_fill_addr = 5'd21; end
         if (e == 4) check("hold ready back", 32'(a_req_ready), 32'd1);
         if (e == 5) a_req_valid = 1'b0;
      end
      check("hold pulse count", 32'(pulses), 32'd2);

      // reset during write-back aborts it
      @(negedge clk);
      a_req_valid = 1'b1; a_wb_en = 1'b1; a_wb_addr = 5'd7; a_wb_data = 8'hFF; a_fill_addr = 5'd7;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort state", 32'({a_resp_valid, a_req_ready, a_busy}), 32'b010);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (a_resp_valid === 1'b1) seen = 1'b1;
      end
      check("abort no resp", 32'(seen), 32'd0);
      run_req(1'b0, 5'd0, 8'h00, 5'd7, 8'h07, LAT_A, "after abort");

      // LAT=1 back-to-back: accept, FILL, RESP repeating
      for (int k = 0; k < 9; k++) v[k] = 5'($urandom);
      @(negedge clk);
      b_req_valid = 1'b1; b_wb_en = 1'b0; b_fill_addr = v[0];
      for (int e = 0; e < 24; e++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("b2b valid e%0d", e), 32'(b_resp_valid), 32'((e % 3) == 1));
         if ((e % 3) == 1) check($sformatf("b2b data e%0d", e), 32'(b_resp_data), 32'(v[e / 3]));
         if ((e % 3) == 0) b_fill_addr = v[e / 3 + 1];
      end
      b_req_valid = 1'b0;

      for (int t = 0; t < 40; t++) begin
         wb = 1'($urandom);
         wa = 5'($urandom);
         wd = 8'($urandom);
         fa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
         if (wb) ref_mem[wa] = wd;
         run_req(wb, wa, wd, fa, ref_mem[fa], model_lat(wb, wa, fa), $sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
